// File: rtl/pc_frame_scheduler_if.sv
// Sample buses around the pulse-compression frame scheduler: DDC in, compressor
// feed out, compressor result in, framed range bins out. No back-pressure anywhere.
interface pc_frame_scheduler_if #(
  parameter int IN_W  = 44,
  parameter int OUT_W = 49,
  parameter int IDX_W = 16
);
  logic             ddc_valid;
  logic [IN_W-1:0]  ddc_i;
  logic [IN_W-1:0]  ddc_q;
  logic             pc_valid_o;
  logic [IN_W-1:0]  pc_i_o;
  logic [IN_W-1:0]  pc_q_o;
  logic             pc_valid_i;
  logic [OUT_W-1:0] pc_i_i;
  logic [OUT_W-1:0] pc_q_i;
  logic             out_valid;
  logic [OUT_W-1:0] out_i;
  logic [OUT_W-1:0] out_q;
  logic [IDX_W-1:0] out_bin;
  logic             out_first;
  logic             out_last;

  modport slave (
    input  ddc_valid, ddc_i, ddc_q, pc_valid_i, pc_i_i, pc_q_i,
    output pc_valid_o, pc_i_o, pc_q_o, out_valid, out_i, out_q, out_bin, out_first, out_last
  );

  modport master (
    output ddc_valid, ddc_i, ddc_q, pc_valid_i, pc_i_i, pc_q_i,
    input  pc_valid_o, pc_i_o, pc_q_o, out_valid, out_i, out_q, out_bin, out_first, out_last
  );
endinterface

// File: rtl/pc_frame_scheduler.sv
// Per-PRI sequencer: feeds N_RANGE DDC samples plus N_TAPS-1 flush zeros into the
// compressor, then keeps only the N_RANGE aligned bins of its full convolution.
module pc_frame_scheduler #(
  parameter int IN_W      = 44,
  parameter int OUT_W     = 49,
  parameter int N_RANGE   = 1024,
  parameter int N_TAPS    = 128,
  parameter int IDX_W     = 16,
  parameter int DRAIN_TMO = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 prt_trig,
  input  logic                 err_clr,
  pc_frame_scheduler_if.slave  bus,
  output logic                 busy,
  output logic                 trig_overrun,
  output logic                 drain_err
);
  localparam int TOTAL = N_RANGE + N_TAPS - 1;
  localparam int TMO_W = $clog2(DRAIN_TMO + 1);
  localparam logic [IDX_W-1:0] FEED_LAST  = IDX_W'(N_RANGE - 1);
  localparam logic [IDX_W-1:0] FLUSH_LAST = IDX_W'(N_TAPS - 2);
  localparam logic [IDX_W-1:0] K_FIRST    = IDX_W'(N_TAPS - 1);
  localparam logic [IDX_W-1:0] K_LAST     = IDX_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0] K_DONE     = IDX_W'(TOTAL);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(DRAIN_TMO - 1);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] feed_cnt_q;
  logic [IDX_W-1:0] flush_cnt_q;
  logic [IDX_W-1:0] out_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             pc_valid_q;
  logic [IN_W-1:0]  pc_i_q;
  logic [IN_W-1:0]  pc_q_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_i_q;
  logic [OUT_W-1:0] out_q_q;
  logic [IDX_W-1:0] out_bin_q;
  logic             out_first_q;
  logic             out_last_q;
  logic             trig_overrun_q;
  logic             drain_err_q;

  // Convolution outputs before K_FIRST are the FIR ramp-up and are discarded.
  logic count_d;
  logic keep_d;
  assign count_d = bus.pc_valid_i && (state_q != IDLE);
  assign keep_d  = count_d && (out_cnt_q >= K_FIRST) && (out_cnt_q <= K_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      feed_cnt_q     <= '0;
      flush_cnt_q    <= '0;
      out_cnt_q      <= '0;
      tmo_cnt_q      <= '0;
      pc_valid_q     <= 1'b0;
      pc_i_q         <= '0;
      pc_q_q         <= '0;
      out_valid_q    <= 1'b0;
      out_i_q        <= '0;
      out_q_q        <= '0;
      out_bin_q      <= '0;
      out_first_q    <= 1'b0;
      out_last_q     <= 1'b0;
      trig_overrun_q <= 1'b0;
      drain_err_q    <= 1'b0;
    end else begin
      pc_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      // Clear first so a coincident new error below takes priority.
      if (err_clr) begin
        trig_overrun_q <= 1'b0;
        drain_err_q    <= 1'b0;
      end
      if (prt_trig && (state_q != IDLE)) trig_overrun_q <= 1'b1;
      if (count_d) out_cnt_q <= out_cnt_q + IDX_W'(1);
      if (keep_d) begin
        out_valid_q <= 1'b1;
        out_i_q     <= bus.pc_i_i;
        out_q_q     <= bus.pc_q_i;
        out_bin_q   <= out_cnt_q - K_FIRST;
        out_first_q <= (out_cnt_q == K_FIRST);
        out_last_q  <= (out_cnt_q == K_LAST);
      end
      case (state_q)
        IDLE: if (prt_trig) begin
          state_q    <= FEED;
          feed_cnt_q <= '0;
          out_cnt_q  <= '0;
        end
        FEED: if (bus.ddc_valid) begin
          pc_valid_q <= 1'b1;
          pc_i_q     <= bus.ddc_i;
          pc_q_q     <= bus.ddc_q;
          feed_cnt_q <= feed_cnt_q + IDX_W'(1);
          if (feed_cnt_q == FEED_LAST) begin
            state_q     <= FLUSH;
            flush_cnt_q <= '0;
          end
        end
        FLUSH: begin
          pc_valid_q  <= 1'b1;
          pc_i_q      <= '0;
          pc_q_q      <= '0;
          flush_cnt_q <= flush_cnt_q + IDX_W'(1);
          if (flush_cnt_q == FLUSH_LAST) begin
            state_q   <= DRAIN;
            tmo_cnt_q <= '0;
          end
        end
        DRAIN: begin
          if (out_cnt_q >= K_DONE) begin
            state_q <= IDLE;
          end else if (bus.pc_valid_i) begin
            tmo_cnt_q <= '0;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q     <= IDLE;
            drain_err_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pc_valid_o = pc_valid_q;
  assign bus.pc_i_o     = pc_i_q;
  assign bus.pc_q_o     = pc_q_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_i      = out_i_q;
  assign bus.out_q      = out_q_q;
  assign bus.out_bin    = out_bin_q;
  assign bus.out_first  = out_first_q;
  assign bus.out_last   = out_last_q;
  assign busy           = (state_q != IDLE);
  assign trig_overrun   = trig_overrun_q;
  assign drain_err      = drain_err_q;
endmodule

// File: tb/tb_pc_frame_scheduler.sv
// Directed bench for pc_frame_scheduler with an identity compressor model
// (5-cycle delay, optional output drop) on N_RANGE=8, N_TAPS=4.
module tb_pc_frame_scheduler;
  localparam int IN_W = 44, OUT_W = 49, N_RANGE = 8, N_TAPS = 4, IDX_W = 16;
  localparam int DRAIN_TMO = 20, DLY = 5, NPC = N_RANGE + N_TAPS - 1;

  logic clk = 1'b0, rst_n = 1'b0, prt_trig = 1'b0, err_clr = 1'b0;
  logic busy, trig_overrun, drain_err;

  pc_frame_scheduler_if #(.IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) ifc ();

  pc_frame_scheduler #(
    .IN_W(IN_W), .OUT_W(OUT_W), .N_RANGE(N_RANGE), .N_TAPS(N_TAPS),
    .IDX_W(IDX_W), .DRAIN_TMO(DRAIN_TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .prt_trig(prt_trig), .err_clr(err_clr),
    .bus(ifc.slave), .busy(busy), .trig_overrun(trig_overrun), .drain_err(drain_err)
  );

  always #5 clk = ~clk;

  // Identity compressor: delays the feed by DLY cycles; can drop everything after 6 outputs.
  logic [DLY-1:0] dv = '0;
  logic [IN_W-1:0] di [DLY];
  logic [IN_W-1:0] dq [DLY];
  int model_cnt = 0;
  int drop_base = 0;
  bit drop_en = 1'b0;
  always @(posedge clk) begin
    dv <= {dv[DLY-2:0], ifc.pc_valid_o};
    di[0] <= ifc.pc_i_o;
    dq[0] <= ifc.pc_q_o;
    for (int k = 1; k < DLY; k++) begin
      di[k] <= di[k-1];
      dq[k] <= dq[k-1];
    end
    if (dv[DLY-1]) model_cnt <= model_cnt + 1;
  end
  assign ifc.pc_valid_i = dv[DLY-1] && !(drop_en && (model_cnt - drop_base) >= 6);
  assign ifc.pc_i_i = {{(OUT_W-IN_W){di[DLY-1][IN_W-1]}}, di[DLY-1]};
  assign ifc.pc_q_i = {{(OUT_W-IN_W){dq[DLY-1][IN_W-1]}}, dq[DLY-1]};

  // Monitors: record every compressor feed strobe and every emitted bin.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [IN_W-1:0]  pc_dat[$];
  int               pc_cyc[$];
  logic [OUT_W-1:0] o_i[$];
  logic [OUT_W-1:0] o_q[$];
  logic [IDX_W-1:0] o_bin[$];
  logic             o_first[$];
  logic             o_last[$];
  always @(negedge clk) begin
    if (ifc.pc_valid_o) begin
      pc_dat.push_back(ifc.pc_i_o);
      pc_cyc.push_back(cyc);
    end
    if (ifc.out_valid) begin
      o_i.push_back(ifc.out_i);
      o_q.push_back(ifc.out_q);
      o_bin.push_back(ifc.out_bin);
      o_first.push_back(ifc.out_first);
      o_last.push_back(ifc.out_last);
      $display("bin %0d i=%0h q=%0h first=%0b last=%0b", ifc.out_bin, ifc.out_i, ifc.out_q,
               ifc.out_first, ifc.out_last);
    end
  end

  int n_pass = 0, n_total = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One PRI: trigger, N_RANGE samples 1..N_RANGE (I=v, Q=-v) spaced gap cycles apart.
  task automatic send_frame(input int gap, input bit coin, input int ovr_at, input int extra);
    @(posedge clk); #1;
    prt_trig = 1'b1;
    if (coin) begin
      ifc.ddc_valid = 1'b1; ifc.ddc_i = IN_W'(99); ifc.ddc_q = IN_W'(-99);
    end
    @(posedge clk); #1;
    prt_trig = 1'b0; ifc.ddc_valid = 1'b0;
    for (int v = 1; v <= N_RANGE; v++) begin
      ifc.ddc_valid = 1'b1; ifc.ddc_i = IN_W'(v); ifc.ddc_q = IN_W'(-v);
      prt_trig = (v == ovr_at);
      @(posedge clk); #1;
      ifc.ddc_valid = 1'b0; prt_trig = 1'b0;
      for (int g = 1; g < gap; g++) begin @(posedge clk); #1; end
    end
    for (int e = 0; e < extra; e++) begin
      ifc.ddc_valid = 1'b1; ifc.ddc_i = IN_W'(77); ifc.ddc_q = IN_W'(77);
      @(posedge clk); #1;
    end
    ifc.ddc_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c = 0;
    while (busy && c < budget) begin @(negedge clk); c++; end
    check({tag, " busy_cleared"}, 64'(busy), 64'(0));
    repeat (8) @(negedge clk);
  endtask

  function automatic logic [OUT_W-1:0] exp_i(input int b);
    int v = (b + N_TAPS <= N_RANGE) ? b + N_TAPS : 0;
    return OUT_W'(v);
  endfunction
  function automatic logic [OUT_W-1:0] exp_q(input int b);
    int v = (b + N_TAPS <= N_RANGE) ? b + N_TAPS : 0;
    return OUT_W'(-v);
  endfunction

  task automatic check_bins(input string tag, input int ob, input int nbins);
    check({tag, " out_count"}, 64'(o_bin.size() - ob), 64'(nbins));
    if (o_bin.size() - ob == nbins) begin
      for (int b = 0; b < nbins; b++) begin
        check($sformatf("%s bin%0d idx", tag, b), 64'(o_bin[ob+b]), 64'(b));
        check($sformatf("%s bin%0d i", tag, b), 64'(o_i[ob+b]), 64'(exp_i(b)));
        check($sformatf("%s bin%0d q", tag, b), 64'(o_q[ob+b]), 64'(exp_q(b)));
        check($sformatf("%s bin%0d first", tag, b), 64'(o_first[ob+b]), 64'(b == 0));
        check($sformatf("%s bin%0d last", tag, b), 64'(o_last[ob+b]), 64'(b == N_RANGE-1));
      end
    end
  endtask

  task automatic check_frame(input string tag, input int pb, input int ob);
    check({tag, " pc_count"}, 64'(pc_dat.size() - pb), 64'(NPC));
    if (pc_dat.size() - pb == NPC) begin
      for (int k = 0; k < NPC; k++)
        check($sformatf("%s pc%0d", tag, k), 64'(pc_dat[pb+k]), (k < N_RANGE) ? 64'(k+1) : 64'(0));
      check({tag, " flush_contig"}, 64'(pc_cyc[pb+NPC-1] - pc_cyc[pb+N_RANGE-1]), 64'(N_TAPS-1));
    end
    check_bins(tag, ob, N_RANGE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int pb, ob, nlast;
    ifc.ddc_valid = 1'b0; ifc.ddc_i = '0; ifc.ddc_q = '0;
    repeat (3) @(negedge clk);
    check("rst pc_valid_o", 64'(ifc.pc_valid_o), 64'(0));
    check("rst out_valid", 64'(ifc.out_valid), 64'(0));
    check("rst out_bin", 64'(ifc.out_bin), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst trig_overrun", 64'(trig_overrun), 64'(0));
    check("rst drain_err", 64'(drain_err), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    pb = pc_dat.size(); ob = o_bin.size();
    send_frame(1, 1'b0, 0, 6);
    wait_idle("basic", 200);
    check_frame("basic", pb, ob);

    pb = pc_dat.size(); ob = o_bin.size();
    send_frame(1, 1'b1, 0, 0);
    wait_idle("coin", 200);
    check_frame("coin", pb, ob);

    pb = pc_dat.size(); ob = o_bin.size();
    send_frame(3, 1'b0, 0, 0);
    wait_idle("gap", 200);
    check_frame("gap", pb, ob);

    pb = pc_dat.size(); ob = o_bin.size();
    send_frame(1, 1'b0, 4, 0);
    check("ovr flag_set", 64'(trig_overrun), 64'(1));
    wait_idle("ovr", 200);
    check_frame("ovr", pb, ob);
    check("ovr flag_held", 64'(trig_overrun), 64'(1));
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    check("ovr flag_cleared", 64'(trig_overrun), 64'(0));

    drop_base = model_cnt; drop_en = 1'b1;
    pb = pc_dat.size(); ob = o_bin.size();
    check("tmo drain_err_before", 64'(drain_err), 64'(0));
    send_frame(1, 1'b0, 0, 0);
    wait_idle("tmo", 300);
    check("tmo drain_err", 64'(drain_err), 64'(1));
    check("tmo pc_count", 64'(pc_dat.size() - pb), 64'(NPC));
    check_bins("tmo", ob, 3);
    nlast = 0;
    for (int k = ob; k < o_last.size(); k++) nlast += int'(o_last[k]);
    check("tmo no_last", 64'(nlast), 64'(0));
    drop_en = 1'b0;

    send_frame(1, 1'b0, 0, 0);
    @(posedge clk); #1;
    check("arst pc_valid_before", 64'(ifc.pc_valid_o), 64'(1));
    rst_n = 1'b0;
    #1;
    check("arst pc_valid_o", 64'(ifc.pc_valid_o), 64'(0));
    check("arst busy", 64'(busy), 64'(0));
    check("arst drain_err", 64'(drain_err), 64'(0));
    check("arst out_bin", 64'(ifc.out_bin), 64'(0));
    check("arst out_valid", 64'(ifc.out_valid), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    ob = o_bin.size();
    repeat (20) @(negedge clk);
    check("arst no_out_after", 64'(o_bin.size() - ob), 64'(0));
    check("arst idle_after", 64'(busy), 64'(0));

    pb = pc_dat.size(); ob = o_bin.size();
    send_frame(1, 1'b0, 0, 0);
    wait_idle("recover", 200);
    check_frame("recover", pb, ob);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
